// File: rtl/line_memory_pkg.sv
// Shared definitions for the line memory responder.
// Holds the word/line geometry, the port FSM state encodings and the helper
// that maps a word index within a line to its bit position on the line bus.
package line_memory_pkg;

   localparam int unsigned WORD_SIZE  = 16;
   localparam int unsigned LINE_WORDS = 4;
   localparam int unsigned LINE_SIZE  = WORD_SIZE * LINE_WORDS;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] ACK  = 2'd2;

   // Word 0 of a line sits in the least significant slice of the bus.
   function automatic int unsigned word_lsb(input int unsigned idx);
      return idx * WORD_SIZE;
   endfunction

endpackage

// File: rtl/line_memory_mem_port_fsm.sv
// Latency-modelled request handshake for one memory port.
// Ports:
//   Clk, Reset   clock, asynchronous active-high reset
//   read_i       line read request (level)
//   write_i      line write request (level, wins over read)
//   addr_i       word address; the line address is addr_i[WORD_SIZE-1:2]
//   line_o       line address of the operation that commits this cycle
//   write_o      operation type of the current/committing operation
//   commit_o     high in the cycle whose rising edge enters ACK
//   ack_o        one-cycle completion pulse
//   conflict_o   read and write both requested at acceptance
module mem_port_fsm
   import line_memory_pkg::*;
#(
   parameter int unsigned LATENCY = 4
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 read_i,
   input  logic                 write_i,
   input  logic [WORD_SIZE-1:0] addr_i,
   output logic [WORD_SIZE-3:0] line_o,
   output logic                 write_o,
   output logic                 commit_o,
   output logic                 ack_o,
   output logic                 conflict_o
);

   localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   logic [1:0]           state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [WORD_SIZE-3:0] line_q, line_d;
   logic                 write_q, write_d;
   logic                 commit;
   logic                 req;
   logic                 held;
   logic                 unused_addr;

   assign req  = read_i | write_i;
   // Only the request that was accepted keeps the operation alive.
   assign held = write_q ? write_i : read_i;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      line_d  = line_q;
      write_d = write_q;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               line_d  = addr_i[WORD_SIZE-1:2];
               write_d = write_i;
               if (LATENCY == 1) begin
                  state_d = ACK;
                  commit  = 1'b1;
               end else begin
                  state_d = BUSY;
                  cnt_d   = CW'(LATENCY - 1);
               end
            end
         end
         BUSY: begin
            if (!held) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               state_d = ACK;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         line_q  <= '0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         line_q  <= line_d;
         write_q <= write_d;
      end
   end

   // Next-state values already carry the live address when LATENCY is 1.
   assign line_o      = line_d;
   assign write_o     = write_d;
   assign commit_o    = commit & ~Reset;
   assign ack_o       = (state_q == ACK);
   assign conflict_o  = (state_q == IDLE) & read_i & write_i & ~Reset;
   assign unused_addr = ^addr_i[1:0];

endmodule

// File: rtl/line_memory.sv
// Dual-port line memory responder for the CPU/cache memory bus.
// Port 1 is read-only (instruction side), port 2 reads or writes whole lines
// over a bidirectional bus. Each port has its own latency-modelled handshake.
// Ports:
//   Clk, Reset          clock, asynchronous active-high reset
//   readM1, address1    port 1 line read request and word address
//   data1, ack1         port 1 line data (zero outside ack) and ack pulse
//   readM2, writeM2     port 2 read/write requests
//   address2            port 2 word address
//   data2               port 2 bus: write data in, read data out during ack
//   ack2                port 2 ack pulse
// Storage has no reset and powers up with undefined contents.
module line_memory
   import line_memory_pkg::*;
#(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 4
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 readM1,
   input  logic [WORD_SIZE-1:0] address1,
   output logic [LINE_SIZE-1:0] data1,
   output logic                 ack1,
   input  logic                 readM2,
   input  logic                 writeM2,
   input  logic [WORD_SIZE-1:0] address2,
   inout  wire  [LINE_SIZE-1:0] data2,
   output logic                 ack2
);

   localparam int unsigned LINE_COUNT = DEPTH / LINE_WORDS;
   localparam int unsigned LINE_AW    = $clog2(LINE_COUNT);
   localparam int unsigned WORD_AW    = $clog2(DEPTH);

   logic [WORD_SIZE-1:0] mem [DEPTH];

   logic [WORD_SIZE-3:0] line1, line2;
   logic                 commit1, commit2;
   logic                 wr1, wr2;
   logic                 conf1, conf2;
   logic [LINE_AW-1:0]   idx1, idx2;
   logic [LINE_SIZE-1:0] line1_rd, line2_rd;
   logic [LINE_SIZE-1:0] rd1_q, rd2_q;
   logic                 conflict2;
   logic                 unused_sink;

   function automatic logic [LINE_AW-1:0] wrap_line(input logic [WORD_SIZE-3:0] l);
      return LINE_AW'(32'(l) % LINE_COUNT);
   endfunction

   function automatic logic [WORD_AW-1:0] word_idx(input logic [LINE_AW-1:0] l,
                                                   input int unsigned w);
      return WORD_AW'(32'(l) * LINE_WORDS + w);
   endfunction

   mem_port_fsm #(
      .LATENCY (LATENCY)
   ) u_port1 (
      .Clk        (Clk),
      .Reset      (Reset),
      .read_i     (readM1),
      .write_i    (1'b0),
      .addr_i     (address1),
      .line_o     (line1),
      .write_o    (wr1),
      .commit_o   (commit1),
      .ack_o      (ack1),
      .conflict_o (conf1)
   );

   mem_port_fsm #(
      .LATENCY (LATENCY)
   ) u_port2 (
      .Clk        (Clk),
      .Reset      (Reset),
      .read_i     (readM2),
      .write_i    (writeM2),
      .addr_i     (address2),
      .line_o     (line2),
      .write_o    (wr2),
      .commit_o   (commit2),
      .ack_o      (ack2),
      .conflict_o (conf2)
   );

   assign idx1 = wrap_line(line1);
   assign idx2 = wrap_line(line2);

   always_comb begin
      line1_rd = '0;
      line2_rd = '0;
      for (int unsigned w = 0; w < LINE_WORDS; w++) begin
         line1_rd[word_lsb(w) +: WORD_SIZE] = mem[word_idx(idx1, w)];
         line2_rd[word_lsb(w) +: WORD_SIZE] = mem[word_idx(idx2, w)];
      end
   end

   // Reads capture on the same edge as a write commit, so a colliding
   // port 1 read returns the pre-write line.
   always_ff @(posedge Clk) begin
      if (commit2 && wr2) begin
         for (int unsigned w = 0; w < LINE_WORDS; w++) begin
            mem[word_idx(idx2, w)] <= data2[word_lsb(w) +: WORD_SIZE];
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rd1_q     <= '0;
         rd2_q     <= '0;
         conflict2 <= 1'b0;
      end else begin
         if (commit1) rd1_q <= line1_rd;
         if (commit2 && !wr2) rd2_q <= line2_rd;
         if (conf2) conflict2 <= 1'b1;
      end
   end

   assign data1 = ack1 ? rd1_q : '0;
   assign data2 = (ack2 && !wr2) ? rd2_q : {LINE_SIZE{1'bz}};

   // conflict2 is a debug flag observed in simulation only.
   assign unused_sink = wr1 ^ conf1 ^ conflict2;

endmodule
